// File: rtl/note_envelope_pwm.sv
// rtl/note_envelope_pwm.sv - ADSR-style note envelope shaping a square-wave tone into PWM audio
module note_envelope_pwm #(
  parameter int TICK_DIV      = 50000,
  parameter int ATTACK_STEP   = 8,
  parameter int DECAY_STEP    = 2,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int RELEASE_STEP  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gate_in,
  input  logic       audio_in,
  output logic       pwm_out,
  output logic [7:0] env_level,
  output logic       busy
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [8:0]    ATTACK9   = 9'(ATTACK_STEP);
  localparam logic [8:0]    DECAY9    = 9'(DECAY_STEP);
  localparam logic [8:0]    RELEASE9  = 9'(RELEASE_STEP);
  localparam logic [8:0]    SUSTAIN9  = 9'(SUSTAIN_LEVEL);
  localparam logic [7:0]    SUSTAIN8  = 8'(SUSTAIN_LEVEL);
  localparam logic [7:0]    DECAY8    = 8'(DECAY_STEP);
  localparam logic [7:0]    RELEASE8  = 8'(RELEASE_STEP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t        state_q;
  logic [7:0]    level_q;
  logic          busy_q;
  logic          gate_s1_q, gate_s2_q, gate_prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    pwm_cnt_q;
  logic          pwm_q;

  logic          rise;
  logic          gate_low;
  logic          tick;
  logic [8:0]    attack_sum;
  logic          attack_clip;
  logic          decay_floor;
  logic          release_floor;

  assign rise     = gate_s2_q & ~gate_prev_q;
  assign gate_low = ~gate_s2_q;
  assign tick     = (tick_cnt_q == TICK_LAST);

  // Saturation decisions are made in 9 bits so the step arithmetic can never wrap.
  assign attack_sum    = {1'b0, level_q} + ATTACK9;
  assign attack_clip   = (attack_sum >= 9'd255);
  assign decay_floor   = ({1'b0, level_q} <= (SUSTAIN9 + DECAY9));
  assign release_floor = ({1'b0, level_q} <= RELEASE9);

  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // Gate synchronizer plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_s1_q   <= 1'b0;
      gate_s2_q   <= 1'b0;
      gate_prev_q <= 1'b0;
    end else begin
      gate_s1_q   <= gate_in;
      gate_s2_q   <= gate_s1_q;
      gate_prev_q <= gate_s2_q;
    end
  end

  // Free-running envelope tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Envelope FSM: retrigger beats gate release, which beats the tick-driven level step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= 8'd0;
      busy_q  <= 1'b0;
    end else if (rise) begin
      state_q <= ST_ATTACK;
      busy_q  <= 1'b1;
    end else if (gate_low && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
      state_q <= ST_RELEASE;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          level_q <= 8'd0;
          busy_q  <= 1'b0;
        end
        ST_ATTACK: begin
          if (tick) begin
            if (attack_clip) begin
              level_q <= 8'd255;
              state_q <= ST_DECAY;
            end else begin
              level_q <= attack_sum[7:0];
            end
          end
        end
        ST_DECAY: begin
          if (tick) begin
            if (decay_floor) begin
              level_q <= SUSTAIN8;
              state_q <= ST_SUSTAIN;
            end else begin
              level_q <= level_q - DECAY8;
            end
          end
        end
        ST_SUSTAIN: begin
          level_q <= SUSTAIN8;
        end
        ST_RELEASE: begin
          if (tick) begin
            if (release_floor) begin
              level_q <= 8'd0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              level_q <= level_q - RELEASE8;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          level_q <= 8'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // PWM carrier counter and amplitude-gated tone output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= audio_in & (pwm_cnt_q < level_q);
    end
  end

  assign pwm_out   = pwm_q;
  assign env_level = level_q;
  assign busy      = busy_q;

endmodule

// File: doc/note_envelope_pwm.md
NOTE_ENVELOPE_PWM -- requirements
Module: note_envelope_pwm

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per envelope tick (legal range >= 2).
REQ-002 Parameter ATTACK_STEP, default 8, level increment per tick in ATTACK (1..255).
REQ-003 Parameter DECAY_STEP, default 2, level decrement per tick in DECAY (1..255).
REQ-004 Parameter SUSTAIN_LEVEL, default 160, level held in SUSTAIN (0..255).
REQ-005 Parameter RELEASE_STEP, default 1, level decrement per tick in RELEASE (1..255).
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 gate_in  input  1  key-pressed gate; asynchronous to clk.
REQ-009 audio_in  input  1  square-wave tone from the tone generator, already in the clk domain.
REQ-010 pwm_out  output  1  registered, amplitude-shaped PWM audio output.
REQ-011 env_level  output  8  current envelope amplitude, unsigned.
REQ-012 busy  output  1  high whenever the envelope state is not IDLE.

Function
REQ-013 gate_in SHALL pass through a two-flop synchronizer; a third register holds the previous synchronized value for edge detection.
REQ-014 rise = sync high and previous low; the FSM enters ATTACK on the 3rd rising clk edge after gate_in rises (setup met).
REQ-015 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert a one-cycle tick when at TICK_DIV-1; it is free-running and independent of the FSM.
REQ-016 FSM states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-017 Transition priority per cycle: rise > synchronized gate low > tick-driven level update.
REQ-018 rise in any state SHALL go to ATTACK with env_level unchanged that cycle (retrigger from current level, no reset to 0).
REQ-019 Synchronized gate low in ATTACK, DECAY or SUSTAIN SHALL go to RELEASE with env_level unchanged that cycle.
REQ-020 ATTACK on tick: env_level = min(255, env_level+ATTACK_STEP), using 9-bit intermediate; go to DECAY on the same edge the new value equals 255.
REQ-021 DECAY on tick: env_level = max(SUSTAIN_LEVEL, env_level-DECAY_STEP); go to SUSTAIN on the same edge the new value equals SUSTAIN_LEVEL.
REQ-022 DECAY entered with env_level <= SUSTAIN_LEVEL SHALL load SUSTAIN_LEVEL on the next tick and go to SUSTAIN.
REQ-023 SUSTAIN SHALL hold env_level = SUSTAIN_LEVEL, ignoring ticks.
REQ-024 RELEASE on tick: env_level = max(0, env_level-RELEASE_STEP) with no underflow; go to IDLE on the same edge the new value equals 0.
REQ-025 IDLE SHALL hold env_level = 0; ticks are ignored.
REQ-026 PWM counter SHALL be 8-bit, increment every clk, and wrap 255 -> 0.
REQ-027 pwm_out SHALL be registered as audio_in AND (pwm counter < env_level): duty cycle = env_level/256, 0 at level 0, 255/256 at level 255.
REQ-028 busy SHALL be registered in step with the state register (high in the cycle after the state leaves IDLE).

Reset
REQ-029 reset SHALL force, asynchronously, state IDLE and clear env_level, pwm_out, busy, the tick counter, the PWM counter and all synchronizer flops to 0.
REQ-030 reset asserted mid-envelope SHALL abort the envelope; after release, a new rise is required to restart.
REQ-031 After reset deasserts, gate_in already high SHALL count as a rise (previous synchronized value starts at 0).

Verification (TICK_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, SUSTAIN_LEVEL=128, RELEASE_STEP=32)
REQ-032 Reset: assert reset mid-operation -> env_level=0, pwm_out=0, busy=0 immediately, without waiting for a clk edge.
REQ-033 Gate held high -> env_level per tick 64, 128, 192, 255, then 239, 223, 207, 191, 175, 159, 143, 128; then SUSTAIN with 128 constant.
REQ-034 Gate dropped in SUSTAIN -> RELEASE with levels 96, 64, 32, 0; then IDLE and busy=0.
REQ-035 Retrigger: gate raised in RELEASE at env_level=64 -> ATTACK with levels 128, 192, 255, with no drop to 0.
REQ-036 PWM at env_level=128, audio_in=1 -> pwm_out high exactly 128 of every 256 cycles; audio_in=0 -> pwm_out constantly 0.
REQ-037 Simultaneous events: gate falls synchronized on a tick cycle in ATTACK -> RELEASE entered and env_level unchanged that cycle.
